// File: rtl/core_pkg.sv
// Shared types and constants for the core's pipeline control logic.
// Forwarding selects, the load result encoding and the hazard FSM states.
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } forward_sel_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        DRAIN = 1'b0,
        RUN   = 1'b1
    } hz_state_t;

    // Memory stage wins over Writeback because it holds the younger result.
    function automatic forward_sel_t fwdSelect(
        input logic [4:0] rs,
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW
    );
        forward_sel_t sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (regWriteM && (rdM == rs)) begin
                sel = FWD_MEM;
            end else if (regWriteW && (rdW == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that counts up on inc and holds at all-ones instead of wrapping.
// Cleared asynchronously by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RV32I pipeline: stall/flush, EX forwarding,
// a post-reset drain sequence and saturating stall/flush event counters.
//
// state | meaning
// DRAIN | flush D and E every cycle while the drain down-counter runs out
// RUN   | normal hazard resolution; terminal until reset
module hazard_unit
    import core_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             Draining
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    hz_state_t    state;
    hz_state_t    stateNext;
    logic [DW-1:0] drainCnt;
    logic [DW-1:0] drainCntNext;

    logic         lwStall;
    logic         stallEvent;
    logic         flushEvent;
    forward_sel_t fwdA;
    forward_sel_t fwdB;

    assign lwStall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));

    // Reset forces the selects to the register file regardless of stage contents.
    assign fwdA = reset ? FWD_RF : fwdSelect(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign fwdB = reset ? FWD_RF : fwdSelect(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardAE = fwdA;
    assign ForwardBE = fwdB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DRAIN;
            drainCnt <= DRAIN_INIT;
        end else begin
            state    <= stateNext;
            drainCnt <= drainCntNext;
        end
    end

    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        StallF       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        Draining     = 1'b0;
        stallEvent   = 1'b0;
        flushEvent   = 1'b0;
        case (state)
            DRAIN: begin
                FlushD   = 1'b1;
                FlushE   = 1'b1;
                Draining = 1'b1;
                if (drainCnt == '0) begin
                    stateNext = RUN;
                end else begin
                    drainCntNext = drainCnt - 1'b1;
                end
            end
            RUN: begin
                // A taken branch redirects the PC, so a pending load-use stall is dropped.
                StallF     = lwStall & ~PCSrcE;
                StallD     = lwStall & ~PCSrcE;
                FlushD     = PCSrcE;
                FlushE     = PCSrcE | lwStall;
                stallEvent = lwStall & ~PCSrcE;
                flushEvent = PCSrcE;
            end
            default: begin
                stateNext = DRAIN;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallEvent),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flushEvent),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized bench for hazard_unit with DRAIN_CYCLES = 2 and CNT_W = 4,
// checked against a cycle-level model built from the hazard rules.
module tb_hazard_unit;

    localparam int DRAIN_N = 2;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, RegWriteM, RegWriteW;
    logic          StallF, StallD, FlushD, FlushE, Draining;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCount, FlushCount;

    int vectors = 0;
    int miscompares = 0;

    // Model state: edges seen since reset release and the two event tallies.
    int edgesSinceRelease = 0;
    int mStall = 0;
    int mFlush = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DRAIN_CYCLES(DRAIN_N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FlushCount(FlushCount), .Draining(Draining)
    );

    function automatic logic [1:0] refFwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit refLoadUse();
        return (ResultSrcE == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkAll();
        bit run, lw, st;
        logic [1:0] fa, fb;
        run = !reset && (edgesSinceRelease >= DRAIN_N);
        lw  = refLoadUse();
        st  = run && lw && !PCSrcE;
        fa  = reset ? 2'b00 : refFwd(Rs1E);
        fb  = reset ? 2'b00 : refFwd(Rs2E);
        chk("StallF",     16'(StallF),     16'(st));
        chk("StallD",     16'(StallD),     16'(st));
        chk("FlushD",     16'(FlushD),     16'(run ? PCSrcE : 1'b1));
        chk("FlushE",     16'(FlushE),     16'(run ? (PCSrcE || lw) : 1'b1));
        chk("Draining",   16'(Draining),   16'(!run));
        chk("ForwardAE",  16'(ForwardAE),  16'(fa));
        chk("ForwardBE",  16'(ForwardBE),  16'(fb));
        chk("StallCount", 16'(StallCount), 16'(mStall));
        chk("FlushCount", 16'(FlushCount), 16'(mFlush));
    endtask

    // Called at posedge+1 with inputs settled: check, take an edge, advance the model.
    task automatic cycle();
        bit run, lw;
        #3;
        checkAll();
        run = !reset && (edgesSinceRelease >= DRAIN_N);
        lw  = refLoadUse();
        @(posedge clk);
        if (!reset) begin
            if (run && lw && !PCSrcE && mStall < CMAX) mStall++;
            if (run && PCSrcE && mFlush < CMAX) mFlush++;
            if (edgesSinceRelease < DRAIN_N) edgesSinceRelease++;
        end
        #1;
    endtask

    task automatic clearInputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        edgesSinceRelease = 0;
        mStall = 0;
        mFlush = 0;
    endtask

    initial begin
        clearInputs();
        applyReset();
        @(posedge clk); #1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (DRAIN_N + 1) cycle();

        // Forwarding priority and the zero-register exclusion.
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 9;
        cycle();
        RegWriteM = 0;
        cycle();
        Rs1E = 0; Rs2E = 5;
        cycle();
        clearInputs();

        // Load-use stall, then the same hazard with a taken branch.
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        cycle();
        PCSrcE = 1;
        cycle();
        cycle();
        cycle();
        PCSrcE = 0;
        cycle();

        // Asynchronous reset mid-RUN with FlushCount at 3.
        clearInputs();
        RdM = 3; RegWriteM = 1; Rs1E = 3;
        applyReset();
        #1;
        checkAll();
        cycle();
        reset = 1'b0;
        repeat (DRAIN_N + 1) cycle();

        // Saturation of the flush counter.
        clearInputs();
        PCSrcE = 1;
        repeat (20) cycle();
        PCSrcE = 0;

        // Random traffic over a small register range so hazards are frequent.
        for (int i = 0; i < 300; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 7) == 0);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                applyReset();
                #1;
                checkAll();
                cycle();
                reset = 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
